// File: rtl/pong_pkg.sv
// Shared types and matrix constants for the 8x8 Pong ball engine.
package pong_pkg;

  typedef enum logic [1:0] {IDLE, SERVE, RUN, SCORE} state_t;

  localparam int unsigned COLS    = 8;
  localparam int unsigned ROWS    = 8;
  localparam logic [2:0]  ROW_A   = 3'd0;
  localparam logic [2:0]  ROW_B   = 3'd7;
  localparam logic [2:0]  PAD_MIN = 3'd1;
  localparam logic [2:0]  PAD_MAX = 3'd6;
  localparam logic [2:0]  SERVE_X = 3'd3;
  localparam logic [2:0]  CENTRE_Y = 3'd3;

  // Signed column offset of the ball from a paddle centre (out-of-range paddles used as-is).
  function automatic logic signed [3:0] pad_off(input logic [2:0] x, input logic [2:0] p);
    return $signed({1'b0, x}) - $signed({1'b0, p});
  endfunction

endpackage

// File: rtl/pong_step_timer.sv
// Ball step strobe generator; with SPEED_UP_EN the interval shrinks on each paddle hit.
module pong_step_timer #(
  parameter int unsigned STEP_TICKS = 2500000,
  parameter int unsigned STEP_DEC   = 250000,
  parameter int unsigned STEP_MIN   = 750000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic reload,
  input  logic hit,
  output logic step_c
);

  localparam int unsigned CW = $clog2(STEP_TICKS + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] interval;

  assign step_c = run && (cnt == interval - CW'(1));

  // Held at zero while not running, so every state entry starts a fresh interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || step_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

`ifdef SPEED_UP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      interval <= CW'(STEP_TICKS);
    end else if (reload) begin
      interval <= CW'(STEP_TICKS);
    end else if (hit) begin
      if (32'(interval) >= STEP_MIN + STEP_DEC) begin
        interval <= interval - CW'(STEP_DEC);
      end else begin
        interval <= CW'(STEP_MIN);
      end
    end
  end
`else
  logic unused_speed;
  assign interval     = CW'(STEP_TICKS);
  assign unused_speed = ^{hit, reload};
`endif

endmodule

// File: rtl/pong_ball.sv
// Pong ball engine: movement, wall/paddle bounces, misses and scoring.
// Optional SPEED_UP_EN macro shortens the step interval on every paddle hit.
module pong_ball
  import pong_pkg::*;
#(
  parameter int unsigned STEP_TICKS = 2500000,
  parameter int unsigned SCORE_HOLD = 4,
  parameter int unsigned WIN_SCORE  = 9,
  parameter int unsigned STEP_DEC   = 250000,
  parameter int unsigned STEP_MIN   = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       playing,
  input  logic [2:0] padA,
  input  logic [2:0] padB,
  output logic [2:0] ball_x,
  output logic [2:0] ball_y,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic       point_pulse,
  output logic       game_over
);

  localparam int unsigned HW = (SCORE_HOLD > 1) ? $clog2(SCORE_HOLD) : 1;

  state_t            state;
  logic signed [1:0] dx, dy;
  logic [HW-1:0]     hold_cnt;

  logic              step_c, run_c, hit_c, serve_go_c, hold_done_c;
  logic signed [3:0] off_a_c, off_b_c;
  logic              row_a_c, row_b_c, hit_a_c, hit_b_c;
  logic signed [1:0] dx_sel_c, dx_new_c;
  logic [4:0]        x_sum_c;
  logic [2:0]        x_new_c, y_new_c;
  logic [3:0]        score_a_inc_c, score_b_inc_c;

  assign run_c = playing && (state != IDLE);

  pong_step_timer #(
    .STEP_TICKS(STEP_TICKS),
    .STEP_DEC  (STEP_DEC),
    .STEP_MIN  (STEP_MIN)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run_c),
    .reload(serve_go_c),
    .hit   (hit_c),
    .step_c(step_c)
  );

  // Next-move arithmetic: paddle tests first, then the wall rule on whichever dx wins.
  always_comb begin
    off_a_c  = pad_off(ball_x, padA);
    off_b_c  = pad_off(ball_x, padB);
    row_a_c  = (ball_y == ROW_A + 3'd1) && dy[1];
    row_b_c  = (ball_y == ROW_B - 3'd1) && !dy[1];
    hit_a_c  = (off_a_c >= -4'sd1) && (off_a_c <= 4'sd1);
    hit_b_c  = (off_b_c >= -4'sd1) && (off_b_c <= 4'sd1);
    dx_sel_c = dx;
    if (row_a_c && hit_a_c) begin
      dx_sel_c = $signed(off_a_c[1:0]);
    end else if (row_b_c && hit_b_c) begin
      dx_sel_c = $signed(off_b_c[1:0]);
    end
    x_sum_c  = {2'b00, ball_x} + {{3{dx_sel_c[1]}}, dx_sel_c};
    dx_new_c = (x_sum_c[4] || x_sum_c[3]) ? -dx_sel_c : dx_sel_c;
    x_new_c  = ball_x + {dx_new_c[1], dx_new_c};
    y_new_c  = ball_y + {dy[1], dy};
    hit_c    = step_c && (state == RUN) && ((row_a_c && hit_a_c) || (row_b_c && hit_b_c));
    hold_done_c   = (hold_cnt == HW'(SCORE_HOLD - 1));
    serve_go_c    = (state == IDLE) ||
                    ((state == SCORE) && step_c && !game_over && hold_done_c);
    score_a_inc_c = (score_a >= 4'(WIN_SCORE)) ? score_a : score_a + 4'd1;
    score_b_inc_c = (score_b >= 4'(WIN_SCORE)) ? score_b : score_b + 4'd1;
  end

  // A playing drop overrides everything, including a point on the same step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ball_x      <= SERVE_X;
      ball_y      <= CENTRE_Y;
      dx          <= 2'sd0;
      dy          <= 2'sd1;
      score_a     <= '0;
      score_b     <= '0;
      point_pulse <= 1'b0;
      game_over   <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      point_pulse <= 1'b0;
      if (!playing) begin
        state     <= IDLE;
        ball_x    <= SERVE_X;
        ball_y    <= CENTRE_Y;
        dx        <= 2'sd0;
        dy        <= 2'sd1;
        score_a   <= '0;
        score_b   <= '0;
        game_over <= 1'b0;
        hold_cnt  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state  <= SERVE;
            ball_x <= SERVE_X;
            ball_y <= CENTRE_Y + 3'd1;
            dx     <= 2'sd0;
            dy     <= 2'sd1;
          end
          SERVE: begin
            if (step_c) state <= RUN;
          end
          RUN: begin
            if (step_c) begin
              if (row_a_c && !hit_a_c) begin
                ball_y      <= ROW_A;
                score_b     <= score_b_inc_c;
                game_over   <= (score_b_inc_c == 4'(WIN_SCORE));
                point_pulse <= 1'b1;
                hold_cnt    <= '0;
                state       <= SCORE;
              end else if (row_b_c && !hit_b_c) begin
                ball_y      <= ROW_B;
                score_a     <= score_a_inc_c;
                game_over   <= (score_a_inc_c == 4'(WIN_SCORE));
                point_pulse <= 1'b1;
                hold_cnt    <= '0;
                state       <= SCORE;
              end else begin
                ball_x <= x_new_c;
                dx     <= dx_new_c;
                if (row_a_c) begin
                  ball_y <= ROW_A + 3'd2;
                  dy     <= 2'sd1;
                end else if (row_b_c) begin
                  ball_y <= ROW_B - 3'd2;
                  dy     <= -2'sd1;
                end else begin
                  ball_y <= y_new_c;
                end
              end
            end
          end
          SCORE: begin
            // dy still points at the conceding side, which is where the serve goes.
            if (step_c && !game_over) begin
              if (hold_done_c) begin
                state    <= SERVE;
                hold_cnt <= '0;
                ball_x   <= SERVE_X;
                ball_y   <= dy[1] ? CENTRE_Y : CENTRE_Y + 3'd1;
                dx       <= 2'sd0;
              end else begin
                hold_cnt <= hold_cnt + HW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
